// File: rtl/mem_bist_sequencer.sv
// Wishbone-master self-test sequencer for the management SRAM.
// Runs word, short and byte phases (write window, read back, compare) and reports on checkbits.
module mem_bist_sequencer #(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000,
    parameter int          NWORDS   = 16,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] checkbits,
    output logic [31:0] fail_adr
);
    typedef enum logic [3:0] {
        S_IDLE, S_PH_START, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT, S_CMP, S_PH_END, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_WORD, PH_SHORT, PH_BYTE} phase_t;

    localparam logic [7:0] K_LAST   = 8'(NWORDS - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  k_q, k_d;
    logic [1:0]  sub_q, sub_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] checkbits_q, checkbits_d;
    logic        pass_q, pass_d;
    logic [31:0] fail_adr_q, fail_adr_d;

    logic [1:0]  sub_last;
    logic [3:0]  sel_cur;
    logic [31:0] pat_mask, pattern, lane_mask, acc_adr;
    logic [7:0]  code_lo;
    logic        last_acc, in_acc, fail;
    logic [7:0]  k_adv;
    logic [1:0]  sub_adv;

    always_comb begin
        sub_last = 2'd0;
        sel_cur  = 4'b1111;
        pat_mask = 32'h0000_0000;
        code_lo  = 8'h40;
        case (phase_q)
            PH_SHORT: begin
                sub_last = 2'd1;
                sel_cur  = sub_q[0] ? 4'b1100 : 4'b0011;
                pat_mask = 32'hFFFF_FFFF;
                code_lo  = 8'h20;
            end
            PH_BYTE: begin
                sub_last = 2'd3;
                sel_cur  = 4'b0001 << sub_q;
                pat_mask = 32'h0F0F_0F0F;
                code_lo  = 8'h10;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{sel_cur[gi]}};
    end

    assign pattern  = {k_q ^ 8'hA5, k_q ^ 8'h5A, k_q ^ 8'hC3, k_q ^ 8'h3C} ^ pat_mask;
    assign acc_adr  = BASE_ADR + {22'd0, k_q, 2'b00};
    assign last_acc = (sub_q == sub_last) && (k_q == K_LAST);
    assign sub_adv  = (sub_q == sub_last) ? 2'd0 : sub_q + 2'd1;
    assign k_adv    = (sub_q != sub_last) ? k_q : (last_acc ? 8'd0 : k_q + 8'd1);

    // Bus outputs are gated by the access states so an async reset clears them at once.
    assign in_acc   = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
    assign wb_cyc_o = in_acc;
    assign wb_stb_o = in_acc;
    assign wb_we_o  = (state_q == S_WR_WAIT);
    assign wb_sel_o = in_acc ? sel_cur : 4'b0000;
    assign wb_adr_o = in_acc ? acc_adr : 32'd0;
    assign wb_dat_o = (state_q == S_WR_WAIT) ? pattern : 32'd0;

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign checkbits = checkbits_q;
    assign fail_adr  = fail_adr_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_WORD;
            k_q         <= 8'd0;
            sub_q       <= 2'd0;
            tmo_q       <= 8'd0;
            rdata_q     <= 32'd0;
            checkbits_q <= 16'h0000;
            pass_q      <= 1'b0;
            fail_adr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            sub_q       <= sub_d;
            tmo_q       <= tmo_d;
            rdata_q     <= rdata_d;
            checkbits_q <= checkbits_d;
            pass_q      <= pass_d;
            fail_adr_q  <= fail_adr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        k_d         = k_q;
        sub_d       = sub_q;
        tmo_d       = tmo_q;
        rdata_d     = rdata_q;
        checkbits_d = checkbits_q;
        pass_d      = pass_q;
        fail_adr_d  = fail_adr_q;
        fail        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    phase_d = PH_WORD;
                    state_d = S_PH_START;
                end
            end
            S_PH_START: begin
                checkbits_d = {8'hA0, code_lo};
                k_d         = 8'd0;
                sub_d       = 2'd0;
                state_d     = S_WR;
            end
            S_WR: begin
                tmo_d   = 8'd0;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wb_ack_i) begin
                    k_d     = k_adv;
                    sub_d   = sub_adv;
                    state_d = last_acc ? S_RD : S_WR;
                end else if (tmo_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_RD: begin
                tmo_d   = 8'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wb_ack_i) begin
                    rdata_d = wb_dat_i;
                    state_d = S_CMP;
                end else if (tmo_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_CMP: begin
                // Only lanes enabled by the current sel take part in the compare.
                if (((rdata_q ^ pattern) & lane_mask) != 32'd0) begin
                    fail = 1'b1;
                end else begin
                    k_d     = k_adv;
                    sub_d   = sub_adv;
                    state_d = last_acc ? S_PH_END : S_RD;
                end
            end
            S_PH_END: begin
                checkbits_d = {8'hAB, code_lo | 8'h01};
                if (phase_q == PH_BYTE) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_t'(phase_q + 2'd1);
                    state_d = S_PH_START;
                end
            end
            S_DONE: begin
                if (start) begin
                    pass_d     = 1'b0;
                    fail_adr_d = 32'd0;
                    phase_d    = PH_WORD;
                    state_d    = S_PH_START;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fail) begin
            checkbits_d = {8'hAB, code_lo};
            fail_adr_d  = acc_adr;
            pass_d      = 1'b0;
            state_d     = S_DONE;
        end
    end
endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Bench for mem_bist_sequencer: SRAM slave with fault knobs, access-list model and per-cycle checker.
module tb_mem_bist_sequencer;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int NW  = 16;
    localparam int TMO = 8;

    logic        clk = 1'b0, resetb = 1'b0, start = 1'b0;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, busy, done, pass;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i, fail_adr;
    logic [15:0] checkbits;

    always #5 clk = ~clk;

    mem_bist_sequencer #(.BASE_ADR(BASE), .NWORDS(NW), .TIMEOUT(TMO)) dut (
        .clock(clk), .resetb(resetb), .start(start),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
        .busy(busy), .done(done), .pass(pass), .checkbits(checkbits), .fail_adr(fail_adr)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: the full access list ----------------
    typedef struct packed {logic we; logic [3:0] sel; logic [31:0] adr; logic [31:0] dat;} acc_t;
    acc_t full_list[$];
    acc_t exp_q[$];

    function automatic logic [31:0] pat(input int ph, input int k);
        logic [7:0]  kb;
        logic [31:0] m;
        kb = 8'(k);
        m  = (ph == 0) ? 32'h0 : (ph == 1) ? 32'hFFFF_FFFF : 32'h0F0F_0F0F;
        return {kb ^ 8'hA5, kb ^ 8'h5A, kb ^ 8'hC3, kb ^ 8'h3C} ^ m;
    endfunction

    function automatic logic [3:0] lane_sel(input int ph, input int s);
        if (ph == 0) return 4'hF;
        if (ph == 1) return (s == 0) ? 4'h3 : 4'hC;
        return 4'(32'd1 << s);
    endfunction

    task automatic build_model();
        acc_t a;
        for (int ph = 0; ph < 3; ph++)
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < NW; k++)
                    for (int s = 0; s < (1 << ph); s++) begin
                        a.we  = (p == 0);
                        a.sel = lane_sel(ph, s);
                        a.adr = BASE + 32'(4 * k);
                        a.dat = a.we ? pat(ph, k) : 32'h0;
                        full_list.push_back(a);
                    end
    endtask

    // ---------------- SRAM slave with fault injection ----------------
    logic [31:0] mem [256];
    int  fault_mode = 0;   // 0 none, 1 stuck bit5 word3, 2 lane2 never written, 3 lane2 masked for sel 0100, 4 no ack short k=2
    bit  rand_dly = 0, mem_clr = 0, chk_acc = 1;
    logic        ack_r = 1'b0;
    logic [31:0] rdat_r = 32'h0;
    int  wcnt = 0, dly = 0;
    assign wb_ack   = ack_r;
    assign wb_dat_i = rdat_r;

    initial begin : slave
        logic        s_cyc, s_we, s_clr;
        logic [3:0]  s_sel;
        logic [31:0] s_adr, s_dat, rd;
        logic [7:0]  idx;
        forever begin
            @(negedge clk);
            s_cyc = wb_cyc; s_we = wb_we; s_sel = wb_sel; s_adr = wb_adr; s_dat = wb_dat_o; s_clr = mem_clr;
            @(posedge clk);
            ack_r <= 1'b0;
            if (s_clr) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            end else if (s_cyc && !ack_r) begin
                if (fault_mode == 4 && s_adr == BASE + 32'd8 && (s_sel == 4'h3 || s_sel == 4'hC)) begin
                    wcnt <= 0;
                end else if (wcnt >= dly) begin
                    ack_r <= 1'b1;
                    wcnt  <= 0;
                    dly   <= rand_dly ? int'($urandom_range(0, 5)) : 0;
                    idx = s_adr[9:2];
                    if (s_we) begin
                        for (int b = 0; b < 4; b++)
                            if (s_sel[b] && !(b == 2 && (fault_mode == 2 || (fault_mode == 3 && s_sel == 4'h4))))
                                mem[idx][b*8 +: 8] <= s_dat[b*8 +: 8];
                    end else begin
                        rd = mem[idx];
                        if (fault_mode == 1 && idx == 8'd3) rd[5] = 1'b0;
                        rdat_r <= rd;
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // ---------------- per-cycle checker ----------------
    logic [15:0] cb_seq[$];
    int last_run = 0;

    initial begin : monitor
        acc_t        e;
        logic        p_cyc = 1'b0, p_ack = 1'b0, p_we = 1'b0;
        logic [3:0]  p_sel = 4'h0;
        logic [31:0] p_adr = 32'h0, p_dat = 32'h0;
        logic [15:0] p_cb = 16'h0;
        int          cyc_run = 0, cb_run = 0;
        forever begin
            @(negedge clk);
            chk32("stb_eq_cyc", 32'(wb_stb), 32'(wb_cyc));
            if (wb_cyc && p_cyc && !p_ack) begin
                chk32("hold_adr", wb_adr, p_adr);
                chk32("hold_sel", 32'(wb_sel), 32'(p_sel));
                chk32("hold_we", 32'(wb_we), 32'(p_we));
                chk32("hold_dat", wb_dat_o, p_dat);
            end
            if (p_cyc && p_ack) chk32("idle_after_ack", 32'(wb_cyc), 32'd0);
            if (wb_cyc && wb_ack && chk_acc) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_access: got adr %h sel %h we %0d, required no access", wb_adr, wb_sel, wb_we);
                end else begin
                    e = exp_q.pop_front();
                    chk32("acc_we", 32'(wb_we), 32'(e.we));
                    chk32("acc_sel", 32'(wb_sel), 32'(e.sel));
                    chk32("acc_adr", wb_adr, e.adr);
                    if (e.we) chk32("acc_dat", wb_dat_o, e.dat);
                end
            end
            if (wb_cyc) cyc_run++;
            else if (cyc_run != 0) begin last_run = cyc_run; cyc_run = 0; end
            if (checkbits !== p_cb) begin
                if (p_cb == 16'hAB41 || p_cb == 16'hAB21) chk32("pass_code_hold", 32'(cb_run), 32'd1);
                if (checkbits != 16'h0) cb_seq.push_back(checkbits);
                cb_run = 1;
            end else begin
                cb_run++;
            end
            p_cyc = wb_cyc; p_ack = wb_ack; p_we = wb_we; p_sel = wb_sel;
            p_adr = wb_adr; p_dat = wb_dat_o; p_cb = checkbits;
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] cseq [6];

    task automatic clear_mem();
        @(posedge clk); #1 mem_clr = 1;
        @(posedge clk); #1 mem_clr = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        chk32("busy_after_start", 32'(busy), 32'd1);
        chk32("done_after_start", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            start = poke && (i == 60 || i == 300);
            if (done) begin got = 1; break; end
        end
        start = 0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", budget);
        end
    endtask

    task automatic run_test(input string name, input int fm, input bit rnd, input bit poke, input int nacc,
                            input int ncodes, input logic [15:0] codes [6], input logic exp_pass,
                            input logic [31:0] exp_fadr);
        int cb_base;
        fault_mode = fm; rand_dly = rnd;
        clear_mem();
        for (int i = 0; i < nacc; i++) exp_q.push_back(full_list[i]);
        cb_base = cb_seq.size();
        pulse_start();
        wait_done(20000, poke);
        repeat (2) @(negedge clk);
        #1;
        chk32("done", 32'(done), 32'd1);
        chk32("busy_in_done", 32'(busy), 32'd0);
        chk32("pass", 32'(pass), 32'(exp_pass));
        chk32("fail_adr", fail_adr, exp_fadr);
        chk32("final_checkbits", 32'(checkbits), 32'(codes[ncodes-1]));
        chk32("code_count", 32'(cb_seq.size() - cb_base), 32'(ncodes));
        for (int j = 0; j < ncodes; j++)
            if (cb_base + j < cb_seq.size()) chk32("code_seq", 32'(cb_seq[cb_base+j]), 32'(codes[j]));
        chk32("accesses_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        $display("test %s: pass=%0d fail_adr=%h checkbits=%h", name, pass, fail_adr, checkbits);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish by 900us, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        build_model();
        chk32("model_len", 32'(full_list.size()), 32'd224);
        chk32("model_pat_w0", pat(0, 0), 32'hA55A_C33C);
        chk32("model_pat_s3", pat(1, 3), 32'h59A6_3FC0);
        chk32("model_pat_b1", pat(2, 1), 32'hAB54_CD32);
        chk32("model_first_read", {27'd0, full_list[16].we, full_list[16].sel}, {27'd0, 1'b0, 4'hF});
        chk32("model_byte_rd_sel", 32'(full_list[162].sel), 32'h4);

        repeat (3) @(posedge clk);
        #1;
        chk32("rst_cyc", 32'(wb_cyc), 32'd0);
        chk32("rst_busy_done_pass", {29'd0, busy, done, pass}, 32'd0);
        chk32("rst_checkbits", 32'(checkbits), 32'd0);
        chk32("rst_fail_adr", fail_adr, 32'd0);
        @(posedge clk); #1 resetb = 1;

        cseq = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11};
        run_test("zero_wait", 0, 0, 0, 224, 6, cseq, 1'b1, 32'h0);
        cseq = '{16'hA040, 16'hAB40, 16'h0, 16'h0, 16'h0, 16'h0};
        run_test("stuck_bit5_word3", 1, 0, 0, 20, 2, cseq, 1'b0, 32'h0000_000C);
        run_test("lane2_dead", 2, 0, 0, 17, 2, cseq, 1'b0, BASE);
        cseq = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB10};
        run_test("lane2_dead_byte", 3, 0, 0, 163, 6, cseq, 1'b0, BASE);
        cseq = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB20, 16'h0, 16'h0};
        run_test("no_ack_short_k2", 4, 0, 0, 36, 4, cseq, 1'b0, BASE + 32'd8);
        chk32("timeout_cyc_len", 32'(last_run), 32'(TMO));
        cseq = '{16'hA040, 16'hAB41, 16'hA020, 16'hAB21, 16'hA010, 16'hAB11};
        run_test("random_wait_restart_poke", 0, 1, 1, 224, 6, cseq, 1'b1, 32'h0);

        rand_dly = 0; fault_mode = 0; chk_acc = 0;
        clear_mem();
        pulse_start();
        begin
            bit seen = 0;
            for (int i = 0; i < 5000; i++) begin
                @(posedge clk); #1;
                if (checkbits == 16'hA010) begin seen = 1; break; end
            end
            chk32("reached_byte_phase", 32'(seen), 32'd1);
        end
        repeat (20) @(posedge clk);
        #3 resetb = 0;
        #1;
        chk32("arst_bus", {wb_cyc, wb_stb, wb_we, wb_sel}, 32'd0);
        chk32("arst_adr", wb_adr, 32'd0);
        chk32("arst_dat", wb_dat_o, 32'd0);
        chk32("arst_status", {29'd0, busy, done, pass}, 32'd0);
        chk32("arst_checkbits", 32'(checkbits), 32'd0);
        chk32("arst_fail_adr", fail_adr, 32'd0);
        $display("test async_reset_in_byte_phase: outputs after reset cyc=%0d checkbits=%h", wb_cyc, checkbits);
        @(posedge clk); #1 resetb = 1; chk_acc = 1;
        run_test("rerun_after_reset", 0, 0, 0, 224, 6, cseq, 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
